// File: rtl/global_defs.sv
// Project-wide types shared by the trace parser and the request queue.
package global_defs;
    localparam int ADDRESS_WIDTH = 33;

    typedef enum logic [1:0] {
        NOP   = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        FENCE = 2'd3
    } parsed_op_t;
endpackage

// File: rtl/request_queue_if.sv
// Parser/scheduler handshake bundle for request_queue.
// head_age is present only when REQUEST_QUEUE_AGE_EN is defined.
interface request_queue_if #(
    parameter int DEPTH     = 16,
    parameter int AGE_WIDTH = 8
);
    import global_defs::*;
    localparam int CW = $clog2(DEPTH) + 1;

    logic                     op_ready_s;
    parsed_op_t               opcode;
    logic [ADDRESS_WIDTH-1:0] address;
    logic                     pop;
    logic                     head_valid;
    parsed_op_t               head_opcode;
    logic [ADDRESS_WIDTH-1:0] head_address;
    logic [CW-1:0]            count;
    logic                     full;
    logic                     empty;
    logic                     overflow;
`ifdef REQUEST_QUEUE_AGE_EN
    logic [AGE_WIDTH-1:0]     head_age;
`endif

    modport master (
        output op_ready_s, opcode, address, pop,
        input  head_valid, head_opcode, head_address, count, full, empty, overflow
`ifdef REQUEST_QUEUE_AGE_EN
        , input head_age
`endif
    );

    modport slave (
        input  op_ready_s, opcode, address, pop,
        output head_valid, head_opcode, head_address, count, full, empty, overflow
`ifdef REQUEST_QUEUE_AGE_EN
        , output head_age
`endif
    );
endinterface

// File: rtl/request_queue.sv
// In-order FIFO of parsed trace ops, filled on rising edges of the parser strobe.
// Define REQUEST_QUEUE_AGE_EN to add per-entry saturating age counters and head_age.
module request_queue #(
    parameter int DEPTH     = 16,
    parameter int AGE_WIDTH = 8
) (
    input logic             clk,
    input logic             rst,
    request_queue_if.slave  bus
);
    import global_defs::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic                     r_strb_q;
    logic [PW-1:0]            r_wr;
    logic [PW-1:0]            r_rd;
    logic [CW-1:0]            r_count;
    logic                     r_overflow;
    parsed_op_t               r_op   [DEPTH];
    logic [ADDRESS_WIDTH-1:0] r_addr [DEPTH];
`ifdef REQUEST_QUEUE_AGE_EN
    logic                     r_vld  [DEPTH];
    logic [AGE_WIDTH-1:0]     r_age  [DEPTH];
`endif

    logic w_nempty;
    logic w_push_valid;
    logic w_pop_eff;
    logic w_push_acc;

    assign w_nempty     = (r_count != '0);
    // NOP strobes are swallowed before they can count toward overflow.
    assign w_push_valid = bus.op_ready_s & ~r_strb_q & (bus.opcode != NOP);
    assign w_pop_eff    = bus.pop & w_nempty;
    assign w_push_acc   = w_push_valid & ((r_count < FULL_CNT) | w_pop_eff);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_strb_q   <= 1'b0;
            r_wr       <= '0;
            r_rd       <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_op[i]   <= NOP;
                r_addr[i] <= '0;
`ifdef REQUEST_QUEUE_AGE_EN
                r_vld[i]  <= 1'b0;
                r_age[i]  <= '0;
`endif
            end
        end else begin
            r_strb_q <= bus.op_ready_s;

            if (w_push_valid && !w_push_acc)
                r_overflow <= 1'b1;

`ifdef REQUEST_QUEUE_AGE_EN
            for (int i = 0; i < DEPTH; i++) begin
                if (r_vld[i] && (r_age[i] != '1))
                    r_age[i] <= r_age[i] + AGE_WIDTH'(1);
            end
`endif

            if (w_pop_eff) begin
                r_rd <= r_rd + PW'(1);
`ifdef REQUEST_QUEUE_AGE_EN
                r_vld[r_rd] <= 1'b0;
`endif
            end

            // On full with simultaneous pop, wr == rd: the write below must win.
            if (w_push_acc) begin
                r_op[r_wr]   <= bus.opcode;
                r_addr[r_wr] <= bus.address;
                r_wr         <= r_wr + PW'(1);
`ifdef REQUEST_QUEUE_AGE_EN
                r_vld[r_wr]  <= 1'b1;
                r_age[r_wr]  <= '0;
`endif
            end

            case ({w_push_acc, w_pop_eff})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.head_valid   = w_nempty;
    assign bus.head_opcode  = w_nempty ? r_op[r_rd] : NOP;
    assign bus.head_address = w_nempty ? r_addr[r_rd] : '0;
    assign bus.count        = r_count;
    assign bus.full         = (r_count == FULL_CNT);
    assign bus.empty        = ~w_nempty;
    assign bus.overflow     = r_overflow;
`ifdef REQUEST_QUEUE_AGE_EN
    assign bus.head_age     = w_nempty ? r_age[r_rd] : '0;
`endif

endmodule

// File: tb/tb_request_queue.sv
// Scoreboard bench for request_queue: stimulus queues expected head entries,
// a negedge monitor checks each effective pop against the queue.
module tb_request_queue;
    import global_defs::*;

    localparam int DEPTH = 16;
    localparam int AW    = 8;
    localparam int AMAX  = (1 << AW) - 1;

    typedef struct packed {
        parsed_op_t               op;
        logic [ADDRESS_WIDTH-1:0] addr;
    } entry_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    entry_t exp_q[$];

    request_queue_if #(.DEPTH(DEPTH), .AGE_WIDTH(AW)) bus ();
    request_queue #(.DEPTH(DEPTH), .AGE_WIDTH(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input parsed_op_t op, input logic [ADDRESS_WIDTH-1:0] a, input bit do_pop);
        bus.op_ready_s = 1'b1;
        bus.opcode     = op;
        bus.address    = a;
        bus.pop        = do_pop;
        tick();
        bus.op_ready_s = 1'b0;
        bus.pop        = 1'b0;
        tick();
    endtask

    task automatic pop_one();
        bus.pop = 1'b1;
        tick();
        bus.pop = 1'b0;
    endtask

    // Monitor: every effective pop must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && bus.pop && bus.head_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop actual_addr=%0h required=no_entry", bus.head_address);
            end else begin
                entry_t e;
                e = exp_q.pop_front();
                chk("pop_opcode", 64'(bus.head_opcode), 64'(e.op));
                chk("pop_address", 64'(bus.head_address), 64'(e.addr));
            end
        end
    end

    initial begin
        bus.op_ready_s = 1'b0;
        bus.opcode     = NOP;
        bus.address    = '0;
        bus.pop        = 1'b0;
        rst            = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        chk("rst_empty", 64'(bus.empty), 64'd1);
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_head_valid", 64'(bus.head_valid), 64'd0);
        chk("rst_full", 64'(bus.full), 64'd0);
        chk("rst_overflow", 64'(bus.overflow), 64'd0);
        chk("rst_head_opcode", 64'(bus.head_opcode), 64'd0);
        chk("rst_head_address", 64'(bus.head_address), 64'd0);

        // Held strobe yields exactly one push.
        bus.op_ready_s = 1'b1;
        bus.opcode     = READ;
        bus.address    = 33'h0_DEAD_BEE0;
        tick();
        chk("push_latency_valid", 64'(bus.head_valid), 64'd1);
        repeat (3) tick();
        bus.op_ready_s = 1'b0;
        tick();
        exp_q.push_back('{READ, 33'h0_DEAD_BEE0});
        chk("held_count", 64'(bus.count), 64'd1);
        chk("held_head_opcode", 64'(bus.head_opcode), 64'(READ));
        chk("held_head_address", 64'(bus.head_address), 64'h0_DEAD_BEE0);
        pop_one();
        chk("held_pop_empty", 64'(bus.empty), 64'd1);

        // Fill to full.
        for (int i = 0; i < 16; i++) begin
            parsed_op_t op;
            op = (i % 2 == 0) ? WRITE : READ;
            strobe(op, 33'(i * 32'h100), 1'b0);
            exp_q.push_back('{op, 33'(i * 32'h100)});
        end
        chk("fill_full", 64'(bus.full), 64'd1);
        chk("fill_count", 64'(bus.count), 64'd16);

        // Push with pop on full is accepted.
        strobe(READ, 33'h1_2345_6780, 1'b1);
        exp_q.push_back('{READ, 33'h1_2345_6780});
        chk("full_pushpop_count", 64'(bus.count), 64'd16);
        chk("full_pushpop_overflow", 64'(bus.overflow), 64'd0);

        // Strobe on full without pop is dropped.
        strobe(WRITE, 33'h1000, 1'b0);
        chk("drop_overflow", 64'(bus.overflow), 64'd1);
        chk("drop_count", 64'(bus.count), 64'd16);

        for (int i = 0; i < 16; i++) pop_one();
        tick();
        chk("drain_empty", 64'(bus.empty), 64'd1);
        chk("drain_overflow_sticky", 64'(bus.overflow), 64'd1);
        pop_one();
        chk("pop_on_empty_count", 64'(bus.count), 64'd0);

        // Push with pop on empty: pop ignored.
        strobe(WRITE, 33'h0_0000_0ABC, 1'b1);
        exp_q.push_back('{WRITE, 33'h0_0000_0ABC});
        chk("empty_pushpop_count", 64'(bus.count), 64'd1);
        pop_one();

        // Alternating push/pop across pointer wrap.
        for (int i = 0; i < 40; i++) begin
            strobe(READ, 33'h1_0000_0000 + 33'(i), 1'b0);
            exp_q.push_back('{READ, 33'h1_0000_0000 + 33'(i)});
            pop_one();
        end
        chk("wrap_empty", 64'(bus.empty), 64'd1);

        // Mid-operation reset.
        for (int i = 0; i < 5; i++) strobe(WRITE, 33'(32'h55 + i), 1'b0);
        chk("pre_rst_count", 64'(bus.count), 64'd5);
        rst = 1'b1;
        #1;
        chk("mid_rst_count", 64'(bus.count), 64'd0);
        chk("mid_rst_empty", 64'(bus.empty), 64'd1);
        chk("mid_rst_head_valid", 64'(bus.head_valid), 64'd0);
        chk("mid_rst_head_address", 64'(bus.head_address), 64'd0);
        chk("mid_rst_overflow", 64'(bus.overflow), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        strobe(NOP, 33'h77, 1'b0);
        chk("nop_count", 64'(bus.count), 64'd0);
        chk("nop_overflow", 64'(bus.overflow), 64'd0);

`ifdef REQUEST_QUEUE_AGE_EN
        bus.op_ready_s = 1'b1;
        bus.opcode     = READ;
        bus.address    = 33'hA0;
        tick();
        bus.op_ready_s = 1'b0;
        exp_q.push_back('{READ, 33'hA0});
        repeat (10) tick();
        chk("age_10", 64'(bus.head_age), 64'd10);
        bus.op_ready_s = 1'b1;
        bus.opcode     = WRITE;
        bus.address    = 33'hB0;
        tick();
        bus.op_ready_s = 1'b0;
        exp_q.push_back('{WRITE, 33'hB0});
        repeat (19) tick();
        chk("age_30_or_sat", 64'(bus.head_age), 64'((AMAX < 30) ? AMAX : 30));
        pop_one();
        chk("age_next_head", 64'(bus.head_age), 64'((AMAX < 20) ? AMAX : 20));
        pop_one();
        chk("age_empty_zero", 64'(bus.head_age), 64'd0);
`endif

        tick();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
